exec_tracker: RTL

- Three-stage in-order execution pipeline directly downstream of the dependency-check stage.
- Accepts keys from the dependency-check stage over a valid/ready handshake and carries them through issue (S0), a multi-cycle execute stage (S1) and writeback (S2).
- Exports the key held in each stage as chk_a/chk_b/chk_c. These feed the dependency-check stage's comparison inputs, so a new key that matches any in-flight key is held back.

---
 rtl/exec_tracker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/exec_tracker.sv
// Three-stage in-order execution tracker (issue / multi-cycle execute / writeback)
// exporting in-flight keys for upstream hazard checks. Optional: TRACK_RETIRE_EN.
module exec_tracker #(
  parameter int unsigned     WIDTH       = 64,
  parameter int unsigned     EXEC_CYCLES = 3,
  parameter logic [WIDTH-1:0] INVALID_KEY = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] chk_a,
  output logic [WIDTH-1:0] chk_b,
  output logic [WIDTH-1:0] chk_c,
  output logic [1:0]       occ
`ifdef TRACK_RETIRE_EN
  ,
  output logic [31:0]      retire_cnt
`endif
);

  localparam int unsigned CNT_W = 8;

  logic             s0_v_q, s0_v_d;
  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s0_d_q, s0_d_d;
  logic [WIDTH-1:0] s1_d_q, s1_d_d;
  logic [WIDTH-1:0] s2_d_q, s2_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] chk_a_q, chk_a_d;
  logic [WIDTH-1:0] chk_b_q, chk_b_d;
  logic [WIDTH-1:0] chk_c_q, chk_c_d;
  logic [1:0]       occ_q, occ_d;

  logic s0_go, s1_go, s2_go, accept;

  // Advance decisions ripple back from writeback so a full pipe can move as one.
  always_comb begin
    s0_v_d  = s0_v_q;
    s1_v_d  = s1_v_q;
    s2_v_d  = s2_v_q;
    s0_d_d  = s0_d_q;
    s1_d_d  = s1_d_q;
    s2_d_d  = s2_d_q;
    cnt_d   = cnt_q;

    s2_go   = s2_v_q & ready_i;
    s1_go   = s1_v_q & (cnt_q == '0) & (~s2_v_q | s2_go);
    s0_go   = s0_v_q & (~s1_v_q | s1_go);
    ready_o = ~s0_v_q | s0_go;
    accept  = valid_i & ready_o;

    if (s1_go) begin
      s2_v_d = 1'b1;
      s2_d_d = s1_d_q;
    end else if (s2_go) begin
      s2_v_d = 1'b0;
    end

    if (s0_go) begin
      s1_v_d = 1'b1;
      s1_d_d = s0_d_q;
      cnt_d  = CNT_W'(EXEC_CYCLES - 1);
    end else begin
      if (s1_go) s1_v_d = 1'b0;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end

    if (accept) begin
      s0_v_d = 1'b1;
      s0_d_d = data_i;
    end else if (s0_go) begin
      s0_v_d = 1'b0;
    end

    // Hazard keys and occupancy are registered from next-state values.
    chk_a_d = s0_v_d ? s0_d_d : INVALID_KEY;
    chk_b_d = s1_v_d ? s1_d_d : INVALID_KEY;
    chk_c_d = s2_v_d ? s2_d_d : INVALID_KEY;
    occ_d   = 2'({1'b0, s0_v_d}) + 2'({1'b0, s1_v_d}) + 2'({1'b0, s2_v_d});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s0_d_q  <= '0;
      s1_d_q  <= '0;
      s2_d_q  <= '0;
      cnt_q   <= '0;
      chk_a_q <= INVALID_KEY;
      chk_b_q <= INVALID_KEY;
      chk_c_q <= INVALID_KEY;
      occ_q   <= 2'd0;
    end else begin
      s0_v_q  <= s0_v_d;
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      s0_d_q  <= s0_d_d;
      s1_d_q  <= s1_d_d;
      s2_d_q  <= s2_d_d;
      cnt_q   <= cnt_d;
      chk_a_q <= chk_a_d;
      chk_b_q <= chk_b_d;
      chk_c_q <= chk_c_d;
      occ_q   <= occ_d;
    end
  end

  assign valid_o = s2_v_q;
  assign data_o  = s2_d_q;
  assign chk_a   = chk_a_q;
  assign chk_b   = chk_b_q;
  assign chk_c   = chk_c_q;
  assign occ     = occ_q;

`ifdef TRACK_RETIRE_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Free-running count of writeback transfers, wraps naturally.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (s2_go) retire_cnt_d = retire_cnt_q + 32'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) retire_cnt_q <= 32'd0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
